// File: rtl/pong_ball.sv
// Ball motion engine: steps the ball once per frame, bounces off walls and paddles, flags a miss.
// Outputs are flops and follow a frame_tick by one clock; there is no backpressure, and LOST holds until reset.
module pong_ball #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SZ     = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_W       = 8,
  parameter int PAD_XA      = 16,
  parameter int PAD_XB      = 616,
  parameter int SPEED       = 2,
  parameter bit SERVE_RIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       frame_tick,
  input  logic [9:0] padA_y,
  input  logic [9:0] padB_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       lossA,
  output logic       lossB
);

  localparam logic [9:0] X_CTR  = 10'((H_RES - BALL_SZ) / 2);
  localparam logic [9:0] Y_CTR  = 10'((V_RES - BALL_SZ) / 2);
  localparam logic [9:0] X_MAX  = 10'(H_RES - BALL_SZ);
  localparam logic [9:0] Y_MAX  = 10'(V_RES - BALL_SZ);
  localparam logic [9:0] FACE_A = 10'(PAD_XA + PAD_W);
  localparam logic [9:0] FACE_B = 10'(PAD_XB - BALL_SZ);
  localparam logic [9:0] SPD    = 10'(SPEED);

  typedef enum logic [1:0] {SERVE, MOVE, LOST} state_t;

  state_t     state;
  logic       dx;   // 1 = towards paddle B
  logic       dy;   // 1 = down
  logic [9:0] x_nxt, y_nxt;
  logic       dx_nxt, dy_nxt;
  logic       bounce, miss_a, miss_b;
  logic       ovl_a, ovl_b;

  // Overlap is evaluated one bit wider so a paddle near the top of the range cannot wrap.
  always_comb begin
    ovl_a = ({1'b0, ball_y} + 11'(BALL_SZ) > {1'b0, padA_y}) &&
            ({1'b0, ball_y} < {1'b0, padA_y} + 11'(PAD_H));
    ovl_b = ({1'b0, ball_y} + 11'(BALL_SZ) > {1'b0, padB_y}) &&
            ({1'b0, ball_y} < {1'b0, padB_y} + 11'(PAD_H));
  end

  always_comb begin
    y_nxt  = ball_y;
    dy_nxt = dy;
    if (dy) begin
      if (ball_y + SPD >= Y_MAX) begin
        y_nxt  = Y_MAX;
        dy_nxt = 1'b0;
      end else begin
        y_nxt = ball_y + SPD;
      end
    end else if (ball_y < SPD) begin
      y_nxt  = '0;
      dy_nxt = 1'b1;
    end else begin
      y_nxt = ball_y - SPD;
    end
  end

  // Paddle test comes first; a ball already past the face misses the paddle and runs on to the wall.
  always_comb begin
    x_nxt  = ball_x;
    dx_nxt = dx;
    bounce = 1'b0;
    miss_a = 1'b0;
    miss_b = 1'b0;
    if (!dx) begin
      if (ball_x >= FACE_A && ball_x - SPD < FACE_A && ovl_a) begin
        x_nxt  = FACE_A;
        dx_nxt = 1'b1;
        bounce = 1'b1;
      end else if (ball_x < SPD) begin
        x_nxt  = '0;
        miss_a = 1'b1;
      end else begin
        x_nxt = ball_x - SPD;
      end
    end else begin
      if (ball_x <= FACE_B && ball_x + SPD > FACE_B && ovl_b) begin
        x_nxt  = FACE_B;
        dx_nxt = 1'b0;
        bounce = 1'b1;
      end else if (ball_x + SPD >= X_MAX) begin
        x_nxt  = X_MAX;
        miss_b = 1'b1;
      end else begin
        x_nxt = ball_x + SPD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SERVE;
      ball_x <= X_CTR;
      ball_y <= Y_CTR;
      dx     <= SERVE_RIGHT;
      dy     <= 1'b1;
      hit    <= 1'b0;
      lossA  <= 1'b0;
      lossB  <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        SERVE: begin
          if (run) state <= MOVE;
        end
        MOVE: begin
          if (run && frame_tick) begin
            ball_x <= x_nxt;
            ball_y <= y_nxt;
            dx     <= dx_nxt;
            dy     <= dy_nxt;
            hit    <= bounce;
            if (miss_a) begin
              lossA <= 1'b1;
              state <= LOST;
            end else if (miss_b) begin
              lossB <= 1'b1;
              state <= LOST;
            end
          end
        end
        LOST: begin
          state <= LOST;
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: hand-traced trajectories from the centre serve.
module tb_pong_ball;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       frame_tick;
  logic [9:0] padA_y;
  logic [9:0] padB_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       hit;
  logic       lossA;
  logic       lossB;

  int n_chk  = 0;
  int n_pass = 0;

  pong_ball dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .frame_tick (frame_tick),
    .padA_y     (padA_y),
    .padB_y     (padB_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .hit        (hit),
    .lossA      (lossA),
    .lossB      (lossB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One frame pulse; returns on the falling edge after the edge that consumed it.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic start_game();
    @(negedge clk) rst_n = 1'b0;
    run = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    frame_tick = 1'b0;
    padA_y     = 10'd0;
    padB_y     = 10'd0;
    repeat (2) @(negedge clk);
    chk("rst_x", ball_x, 316);
    chk("rst_y", ball_y, 236);
    chk("rst_hit", hit, 0);
    chk("rst_lossA", lossA, 0);
    chk("rst_lossB", lossB, 0);

    // SERVE ignores frame ticks while run is low, and the entry cycle does not move.
    rst_n = 1'b1;
    ticks(3);
    chk("serve_hold_x", ball_x, 316);
    chk("serve_hold_y", ball_y, 236);
    @(negedge clk) run = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("serve_entry_x", ball_x, 316);
    chk("serve_entry_y", ball_y, 236);

    ticks(10);
    chk("t10_x", ball_x, 336);
    chk("t10_y", ball_y, 256);
    chk("t10_hit", hit, 0);
    chk("t10_lossA", lossA, 0);
    chk("t10_lossB", lossB, 0);

    run = 1'b0;
    ticks(4);
    chk("pause_x", ball_x, 336);
    chk("pause_y", ball_y, 256);
    run = 1'b1;
    ticks(1);
    chk("resume_x", ball_x, 338);
    chk("resume_y", ball_y, 258);

    // Right-side miss with paddle B out of the way; bottom wall bounce on the way.
    padB_y = 10'd0;
    start_game();
    ticks(117);
    chk("bot_pre_y", ball_y, 470);
    chk("bot_pre_x", ball_x, 550);
    ticks(1);
    chk("bot_y", ball_y, 472);
    ticks(1);
    chk("bot_post_y", ball_y, 470);
    ticks(38);
    chk("edgeB_pre_x", ball_x, 630);
    chk("edgeB_pre_loss", lossB, 0);
    ticks(1);
    chk("edgeB_x", ball_x, 632);
    chk("edgeB_y", ball_y, 392);
    chk("edgeB_lossB", lossB, 1);
    chk("edgeB_lossA", lossA, 0);
    ticks(5);
    chk("lost_x", ball_x, 632);
    chk("lost_y", ball_y, 392);
    chk("lost_lossB", lossB, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", ball_x, 316);
    chk("arst_y", ball_y, 236);
    chk("arst_lossB", lossB, 0);

    // Paddle B returns the ball, paddle A returns it again.
    padB_y = 10'd400;
    padA_y = 10'd150;
    start_game();
    ticks(146);
    chk("padB_pre_x", ball_x, 608);
    chk("padB_pre_hit", hit, 0);
    ticks(1);
    chk("padB_x", ball_x, 608);
    chk("padB_hit", hit, 1);
    @(negedge clk);
    chk("padB_hit_drop", hit, 0);
    ticks(1);
    chk("padB_post_x", ball_x, 606);
    ticks(291);
    chk("padA_pre_x", ball_x, 24);
    chk("padA_pre_hit", hit, 0);
    ticks(1);
    chk("padA_x", ball_x, 24);
    chk("padA_hit", hit, 1);
    @(negedge clk);
    chk("padA_hit_drop", hit, 0);
    ticks(1);
    chk("padA_post_x", ball_x, 26);

    // Paddle A out of the way: ball passes the face and reaches the left wall.
    padA_y = 10'd400;
    start_game();
    ticks(451);
    chk("passA_x", ball_x, 0);
    chk("passA_hit", hit, 0);
    ticks(1);
    chk("lossA_x", ball_x, 0);
    chk("lossA_lvl", lossA, 1);
    chk("lossA_lossB", lossB, 0);
    ticks(3);
    chk("lossA_hold", lossA, 1);
    chk("lossA_frozen_x", ball_x, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
